// File: rtl/adc_stream_pkg.sv
// Shared types and sizing helpers for the ADC capture/stream engine.
package adc_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HOLD,
    RD,
    TX,
    WAIT
  } state_t;

  // Widths at the default buffer depth; instances derive their own with the helpers below.
  localparam int unsigned DEPTH_DEFAULT = 512;
  localparam int unsigned PTR_W         = $clog2(DEPTH_DEFAULT);
  localparam int unsigned CNT_W         = $clog2(DEPTH_DEFAULT + 1);

  // Pointer/index width, never below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Occupancy counter width: must hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return unsigned'($clog2(n + 1));
  endfunction

  // Channel index width, never below one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no reset.
module sample_ram #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus one-cycle registered read (old data on same-address collision).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_capture_streamer.sv
// Tracks latest ADC conversion per channel, decimates, records into a ring/one-shot
// buffer and streams the buffer oldest-first over a start/done handshake.
module adc_capture_streamer
  import adc_stream_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned DIV      = 97656
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adc_valid,
  input  logic [ch_width(CHANNELS)-1:0] adc_ch,
  input  logic [SAMPLE_W-1:0]           adc_data,
  input  logic [ch_width(CHANNELS)-1:0] ch_sel,
  input  logic                          mode,
  input  logic                          arm,
  input  logic                          dump,
  output logic                          sample_stb,
  output logic [SAMPLE_W-1:0]           sample_data,
  output logic                          tx_start,
  output logic [SAMPLE_W-1:0]           tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic                          full,
  output logic                          frame_done
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned DW = ptr_width(DIV);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t              state;
  logic [DW-1:0]       div_cnt;
  logic                tick_c;
  logic [SAMPLE_W-1:0] latest [CHANNELS];
  logic [SAMPLE_W-1:0] sel_sample_c;
  logic [CW-1:0]       count;
  logic [CW-1:0]       sent;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                snap;
  logic                wr_en_c;
  logic [CW-1:0]       cnt_after_c;
  logic [PW-1:0]       wr_after_c;
  logic [PW-1:0]       rd_addr_c;
  logic [SAMPLE_W-1:0] ram_q;
  logic                fwd_hit;
  logic [SAMPLE_W-1:0] fwd_data;

  assign tick_c = (div_cnt == DIV_LAST);

  // Free-running sample-rate divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Latest conversion per channel; out-of-range channel indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        latest[c] <= '0;
      end
    end else if (adc_valid) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (32'(adc_ch) == c) begin
          latest[c] <= adc_data;
        end
      end
    end
  end

  // Selected channel, with a same-cycle conversion bypassing the latest[] register.
  always_comb begin
    sel_sample_c = '0;
    if (32'(ch_sel) < CHANNELS) begin
      sel_sample_c = latest[ch_sel];
      if (adc_valid && (adc_ch == ch_sel)) begin
        sel_sample_c = adc_data;
      end
    end
  end

  // Registered decimated sample strobe and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_stb  <= 1'b0;
      sample_data <= '0;
    end else begin
      sample_stb <= tick_c;
      if (tick_c) begin
        sample_data <= sel_sample_c;
      end
    end
  end

  // Buffer write bookkeeping and next read address (RAM is addressed one cycle early).
  always_comb begin
    wr_en_c     = sample_stb && (state == CAPTURE);
    cnt_after_c = count;
    wr_after_c  = wr_ptr;
    if (wr_en_c) begin
      wr_after_c = wr_ptr + 1'b1;
      if (count != DEPTH_C) begin
        cnt_after_c = count + 1'b1;
      end
    end
    rd_addr_c = rd_ptr;
    case (state)
      CAPTURE, HOLD: rd_addr_c = (cnt_after_c == DEPTH_C) ? wr_after_c : '0;
      WAIT:          if (tx_done) rd_addr_c = rd_ptr + 1'b1;
      default:       rd_addr_c = rd_ptr;
    endcase
  end

  sample_ram #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH),
    .ADDR_W(PW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en_c),
    .wr_addr(wr_ptr),
    .wr_data(sample_data),
    .rd_addr(rd_addr_c),
    .rd_data(ram_q)
  );

  // Forward a word written on the same edge the first read address is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= wr_en_c && (rd_addr_c == wr_ptr);
      fwd_data <= sample_data;
    end
  end

  // Capture / readout state machine with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      sent       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      snap       <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state  <= CAPTURE;
            count  <= '0;
            wr_ptr <= '0;
            snap   <= mode;
          end
        end
        CAPTURE: begin
          if (arm) begin
            count  <= '0;
            wr_ptr <= '0;
            snap   <= mode;
          end else if (dump && (cnt_after_c != '0)) begin
            state  <= RD;
            busy   <= 1'b1;
            count  <= cnt_after_c;
            wr_ptr <= wr_after_c;
            rd_ptr <= rd_addr_c;
            sent   <= '0;
          end else begin
            count  <= cnt_after_c;
            wr_ptr <= wr_after_c;
            if (snap && (cnt_after_c == DEPTH_C)) begin
              state <= HOLD;
              full  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (arm) begin
            state  <= CAPTURE;
            full   <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            snap   <= mode;
          end else if (dump) begin
            state  <= RD;
            full   <= 1'b0;
            busy   <= 1'b1;
            rd_ptr <= rd_addr_c;
            sent   <= '0;
          end
        end
        RD: begin
          tx_data  <= fwd_hit ? fwd_data : ram_q;
          tx_start <= 1'b1;
          state    <= TX;
        end
        TX: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            sent   <= sent + 1'b1;
            rd_ptr <= rd_addr_c;
            if ((sent + 1'b1) == count) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= snap ? IDLE : CAPTURE;
            end else begin
              state <= RD;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          full  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_streamer.sv
// Directed/randomised bench for adc_capture_streamer with a queue-based buffer model.
module tb_adc_capture_streamer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV   = 4;
  localparam int unsigned PER   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic        adc_ch = 1'b0;
  logic [15:0] adc_data = '0;
  logic        ch_sel = 1'b0;
  logic        mode = 1'b0;
  logic        arm = 1'b0;
  logic        dump = 1'b0;
  logic        tx_done = 1'b0;
  logic        sample_stb, tx_start, busy, full, frame_done;
  logic [15:0] sample_data, tx_data;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int txs_cnt = 0;
  int tx_cd = 0;
  logic [15:0] got [$];
  logic [15:0] rec [$];

  always #(PER / 2) clk = ~clk;

  adc_capture_streamer #(
    .CHANNELS(2),
    .SAMPLE_W(16),
    .DEPTH   (DEPTH),
    .DIV     (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_valid  (adc_valid),
    .adc_ch     (adc_ch),
    .adc_data   (adc_data),
    .ch_sel     (ch_sel),
    .mode       (mode),
    .arm        (arm),
    .dump       (dump),
    .sample_stb (sample_stb),
    .sample_data(sample_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .full       (full),
    .frame_done (frame_done)
  );

  // Transmitter model: tx_done three cycles after each tx_start; logs words and frames.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_cd   = 0;
      tx_done = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (tx_cd > 0) begin
        tx_cd--;
        if (tx_cd == 0) tx_done = 1'b1;
      end
      if (tx_start) begin
        got.push_back(tx_data);
        txs_cnt++;
        tx_cd = 3;
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_stb"},   {31'b0, sample_stb}, 0);
    chk({tag, "_sdata"}, {16'b0, sample_data}, 0);
    chk({tag, "_start"}, {31'b0, tx_start}, 0);
    chk({tag, "_txd"},   {16'b0, tx_data}, 0);
    chk({tag, "_busy"},  {31'b0, busy}, 0);
    chk({tag, "_full"},  {31'b0, full}, 0);
    chk({tag, "_fdone"}, {31'b0, frame_done}, 0);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_stb && n < 20);
    chk("tick_seen", {31'b0, sample_stb}, 1);
  endtask

  task automatic pulse_valid(input logic ch, input logic [15:0] v);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = v;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic do_arm(input logic m);
    wait_tick();
    mode = m;
    arm  = 1'b1;
    rec.delete();
    @(negedge clk);
    arm = 1'b0;
  endtask

  // One recorded ring tick: model keeps only the newest DEPTH samples.
  task automatic ring_tick(input logic [15:0] v);
    pulse_valid(1'b0, v);
    wait_tick();
    chk("ring_sdata", {16'b0, sample_data}, {16'b0, v});
    rec.push_back(v);
    if (rec.size() > DEPTH) rec.delete(0);
  endtask

  task automatic do_dump(input string tag);
    int base, fd0, n;
    base = got.size();
    fd0  = fd_cnt;
    dump = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 1);
    chk({tag, "_start_early"}, {31'b0, tx_start}, 0);
    @(negedge clk);
    chk({tag, "_start_lat"}, {31'b0, tx_start}, 1);
    n = 0;
    while (fd_cnt == fd0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_frames"}, fd_cnt - fd0, 1);
    chk({tag, "_busy_end"}, {31'b0, busy}, 0);
    chk({tag, "_words"}, got.size() - base, rec.size());
    for (int i = 0; i < rec.size(); i++) begin
      if (base + i < got.size())
        chk({tag, "_word"}, {16'b0, got[base + i]}, {16'b0, rec[i]});
    end
  endtask

  task automatic dump_ignored(input string tag);
    int t0;
    t0   = txs_cnt;
    dump = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    repeat (12) @(negedge clk);
    chk({tag, "_no_start"}, txs_cnt - t0, 0);
    chk({tag, "_not_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_prev;
    int  t0, n;
    int  lens [3];

    // Reset values
    #3;
    chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Channel tracking and decimation rate
    pulse_valid(1'b0, 16'h1234);
    pulse_valid(1'b1, 16'hABCD);
    ch_sel = 1'b0;
    wait_tick();
    t_prev = $time;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      chk("ch0_data", {16'b0, sample_data}, 32'h1234);
      chk("tick_period", 32'($time - t_prev), DIV * PER);
      t_prev = $time;
    end
    ch_sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_tick();
      chk("ch1_data", {16'b0, sample_data}, 32'hABCD);
    end
    ch_sel = 1'b0;

    // Snapshot: ramp 1..9, only the first DEPTH recorded
    do_arm(1'b1);
    for (int v = 1; v <= 9; v++) begin
      pulse_valid(1'b0, 16'(v));
      chk("snap_full", {31'b0, full}, (v == 9) ? 1 : 0);
      wait_tick();
      chk("snap_sdata", {16'b0, sample_data}, v);
      if (rec.size() < DEPTH) rec.push_back(16'(v));
    end
    do_dump("snap");
    chk("snap_full_after", {31'b0, full}, 0);
    dump_ignored("snap_idle");

    // Ring wrap: 11 random ticks, newest 8 expected
    do_arm(1'b0);
    for (int i = 0; i < 11; i++) ring_tick(16'($urandom()));
    do_dump("ring_wrap");

    // Dump with nothing recorded, then a partial ring
    do_arm(1'b0);
    dump_ignored("empty");
    do_arm(1'b0);
    for (int i = 0; i < 3; i++) ring_tick(16'($urandom()));
    do_dump("partial");

    // Random-length ring captures, including a single-sample frame
    lens[0] = 1;
    lens[1] = 32'($urandom_range(2, 14));
    lens[2] = 32'($urandom_range(2, 14));
    foreach (lens[k]) begin
      do_arm(1'b0);
      for (int i = 0; i < lens[k]; i++) ring_tick(16'($urandom()));
      do_dump("rand_ring");
    end

    // Reset while waiting for tx_done
    do_arm(1'b0);
    for (int i = 0; i < 5; i++) ring_tick(16'($urandom()));
    dump = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_start", {31'b0, tx_start}, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    t0 = txs_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_restart", txs_cnt - t0, 0);
    chk("rst_idle_busy", {31'b0, busy}, 0);
    do_arm(1'b0);
    for (int i = 0; i < 2; i++) ring_tick(16'($urandom()));
    do_dump("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_capture_streamer.md
# adc_capture_streamer

Parametrised capture/stream engine between the XADC DRP read port and the UART transmitter. Tracks the latest conversion per aux channel, decimates to a programmable sample rate, feeds the FFT sample strobe and records samples into a circular or one-shot buffer. On request, streams the buffer oldest-first to the transmitter over a start/done handshake. Supersedes the fixed 512-word, two-channel, free-running capture-and-dump logic in the top level.

## Interface

Parameters:
- `CHANNELS`, 2: number of aux channels tracked, ≥1.
- `SAMPLE_W`, 16: ADC word width.
- `DEPTH`, 512: buffer depth in words, power of two.
- `DIV`, 97656: clocks per sample tick, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `adc_valid` in 1: conversion-valid pulse (eoc/drdy).
- `adc_ch` in `$clog2(CHANNELS)`: channel index of `adc_data`.
- `adc_data` in `SAMPLE_W`: conversion result.
- `ch_sel` in `$clog2(CHANNELS)`: channel decimated and recorded.
- `mode` in 1: 0 = ring capture, 1 = one-shot snapshot. Latched on `arm`.
- `arm` in 1: pulse; starts capture.
- `dump` in 1: pulse; requests buffer readout.
- `sample_stb` out 1: one-cycle strobe per tick.
- `sample_data` out `SAMPLE_W`: decimated sample.
- `tx_start` out 1: one-cycle transmit request.
- `tx_data` out `SAMPLE_W`: word to transmit.
- `tx_done` in 1: transmitter finished word.
- `busy` out 1: readout in progress.
- `full` out 1: snapshot complete, frozen.
- `frame_done` out 1: one-cycle pulse after last word acknowledged.

## Operation

- `latest[c]` is updated on `adc_valid` when `adc_ch == c`. An `adc_ch` value ≥ `CHANNELS` is ignored.
- The divider counts 0..`DIV`-1 continuously in all states. At terminal count the tick fires: `sample_data <= latest[ch_sel]`, `sample_stb` = 1.
- State machine:
  - IDLE: no recording. `arm` → CAPTURE; clears `count` and `wr_ptr`, latches `mode`.
  - CAPTURE: each tick writes `buf[wr_ptr]`, then `wr_ptr = (wr_ptr + 1) mod DEPTH` and `count = min(count + 1, DEPTH)`.
    - In snapshot mode, when `count` reaches `DEPTH` → HOLD.
    - `dump` with `count` > 0 → RD. `dump` with `count == 0` is ignored.
    - `arm` restarts capture: clears `count` and `wr_ptr`.
  - HOLD: `full` = 1. `dump` → RD. `arm` → CAPTURE (cleared).
  - RD: presents `rd_ptr` to the RAM. On entry from CAPTURE/HOLD, `rd_ptr` = `count == DEPTH ? wr_ptr : 0` and `sent` = 0 → TX.
  - TX: `tx_data` <= RAM output, `tx_start` = 1 → WAIT.
  - WAIT: on `tx_done`, `sent++` and `rd_ptr++` (mod `DEPTH`).
    - If `sent == count`: `frame_done` pulse, then CAPTURE in ring mode (`count` and `wr_ptr` preserved) or IDLE in snapshot mode.
    - Otherwise → RD.
- Recording is frozen in RD/TX/WAIT; ticks are not written, but `sample_stb` still fires. `arm` and `dump` are ignored in these states.
- `busy` = 1 in RD, TX and WAIT.

## Timing

- Reset values: all outputs 0, state IDLE, divider 0, `latest[]` 0. Buffer contents are not reset.
- `sample_stb` and `sample_data` are registered: they appear in the cycle after divider terminal count. The buffer write occurs in that same cycle.
- An `adc_valid` in the terminal-count cycle is visible to that tick.
- RAM read latency is 1 cycle. `tx_start` is asserted 2 cycles after `dump` or after the previous `tx_done`.
- `tx_done` is sampled only in WAIT.
- Tick and `dump` in the same CAPTURE cycle: the sample is written and is included in the readout.
- Reset mid-readout: `tx_start`/`busy` drop immediately; the block returns to IDLE and needs `arm` to capture again.

## Structure

- Package `adc_stream_pkg` holds:
  - the state enum (IDLE, CAPTURE, HOLD, RD, TX, WAIT);
  - `PTR_W = $clog2(DEPTH)`;
  - `CNT_W = $clog2(DEPTH+1)`.
- Sub-module `sample_ram`: simple dual-port synchronous RAM, one write port and one registered read port, no reset.

## Test plan

Bench parameters: `DIV`=4, `DEPTH`=8, `CHANNELS`=2. Transmitter model answers each `tx_start` with `tx_done` 3 cycles later.

- Reset asserted mid-run → every output 0 within the same cycle; state IDLE.
- `adc_valid` with ch0 = 0x1234 and ch1 = 0xABCD, `ch_sel`=0 → `sample_stb` every 4 cycles with `sample_data` 0x1234. With `ch_sel`=1 → 0xABCD.
- Snapshot: `arm` with `mode`=1, ch0 ramps 1..9 per tick → `full` after the 8th tick; `dump` → `tx_data` 1..8 in order, `frame_done` once, back to IDLE. Value 9 is never sent.
- Ring wrap: `mode`=0, 11 ticks (values 1..11), then `dump` → 4..11 sent.
- Partial ring: 3 ticks (values 1..3), `dump` → exactly 3 words; `dump` with `count == 0` → no `tx_start`.
- Reset during WAIT → `tx_start` never re-asserts; `arm` then 2 ticks and `dump` → 2 words sent correctly.
